uart_rx_ctrl: RTL

//  Receive-side controller that sequences the 1-bit-per-clock UART receive core.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive controller
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RECV  = 2'd2,
    BREAK = 2'd3
  } rx_ctrl_state_t;

  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO; a push into a full FIFO is accepted only with a same-cycle pop
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - sequences the rx core: idle qualification, start-bit enable,
// frame supervision (framing error, break, watchdog) and byte buffering
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IDLE_MIN  = 2,
  parameter int BREAK_LEN = 12,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ctrl_en,
  input  logic                     rx_line,
  output logic                     core_en,
  input  logic [7:0]               core_data,
  input  logic                     core_done,
  input  logic                     core_busy,
  input  logic                     core_error,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     timeout,
  output logic                     break_det,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         ovr_cnt,
  input  logic                     stat_clr
);

  localparam int IW = $clog2(IDLE_MIN + 1);
  localparam int BW = $clog2(BREAK_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  rx_ctrl_state_t state;
  logic [IW-1:0]  idle_cnt;
  logic [BW-1:0]  brk_cnt;
  logic [WW-1:0]  wdog;
  logic           bad;

  logic       recv_done, push_req, bad_done, brk_hit, wd_hit, ovr_hit, pop;
  logic       full, empty;
  logic [7:0] head;

  assign core_en   = (state == READY) & ctrl_en & ~rx_line;
  assign recv_done = (state == RECV) & core_done;
  assign push_req  = recv_done & ~bad & ~core_error;
  assign bad_done  = recv_done & (bad | core_error);
  assign brk_hit   = (state == RECV) & ~core_done & core_error & (brk_cnt == BW'(BREAK_LEN - 1));
  // The watchdog targets a silent core; while core_error is up the break detector owns the frame.
  assign wd_hit    = (state == RECV) & ~core_done & ~core_error & (wdog == WW'(TIMEOUT - 1));
  assign pop       = m_valid & m_ready;
  assign ovr_hit   = push_req & full & ~pop;

  assign m_valid = ~empty;
  assign m_data  = m_valid ? head : 8'h00;

  uart_rx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (core_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      brk_cnt   <= '0;
      wdog      <= '0;
      bad       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      break_det <= 1'b0;
      err_cnt   <= '0;
      ovr_cnt   <= '0;
    end else begin
      frame_err <= bad_done | brk_hit;
      overrun   <= ovr_hit;
      timeout   <= wd_hit;

      if (stat_clr) begin
        err_cnt <= '0;
        ovr_cnt <= '0;
      end else begin
        if (bad_done | brk_hit) err_cnt <= sat_inc(err_cnt);
        if (ovr_hit)            ovr_cnt <= sat_inc(ovr_cnt);
      end

      case (state)
        IDLE: begin
          // A core still finishing an earlier frame does not count as idle line.
          if (rx_line & ~core_busy) begin
            if (idle_cnt == IW'(IDLE_MIN - 1)) begin
              state    <= READY;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        READY: begin
          if (core_en) begin
            state   <= RECV;
            wdog    <= '0;
            brk_cnt <= '0;
            bad     <= 1'b0;
          end
        end
        RECV: begin
          if (core_done) begin
            state <= IDLE;
          end else if (brk_hit) begin
            state     <= BREAK;
            break_det <= 1'b1;
          end else if (wd_hit) begin
            state <= IDLE;
          end else if (core_error) begin
            bad     <= 1'b1;
            brk_cnt <= brk_cnt + BW'(1);
          end else begin
            brk_cnt <= '0;
            wdog    <= wdog + WW'(1);
          end
        end
        BREAK: begin
          if (core_done) begin
            state     <= IDLE;
            break_det <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
